stopwatch_display: RTL and testbench
====================================

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, clk_c cycles each digit is driven per scan slot (minimum 2).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, clk_c cycles per blink half-period (minimum 2).
REQ-003 The block SHALL have port clk_c, input, 1, system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have ports sec_ones, sec_tens, min_ones, min_tens, input, 4 each, live BCD digits from the stopwatch counter.
REQ-006 The block SHALL have port adj, input, 1, adjust mode active.
REQ-007 The block SHALL have port sel, input, 2, digit under adjustment: 00 sec_ones, 01 sec_tens, 10 min_ones, 11 min_tens.
REQ-008 The block SHALL have port an, output, 4, active-low anode enables; bit k drives scan slot k.
REQ-009 The block SHALL have port seg, output, 7, active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp, output, 1, active-low decimal point (minutes/seconds separator).

Function
REQ-011 Refresh counter rc SHALL count 0..REFRESH_DIV-1 and wrap; at rc==REFRESH_DIV-1, scan index idx (2 bits) SHALL advance idx+1 mod 4.
REQ-012 Slot mapping SHALL be idx0 sec_ones, idx1 sec_tens, idx2 min_ones, idx3 min_tens.
REQ-013 Shadow digit registers SHALL load all four live inputs simultaneously only on the cycle where rc==REFRESH_DIV-1 and idx==3 (frame boundary); no tearing within a frame.
REQ-014 an, seg, dp SHALL be registered, computed from current idx and shadow digits; outputs lag idx by one clk_c cycle.
REQ-015 an SHALL have exactly bit idx low, others high, except when blanked (REQ-018), then 4'b1111.
REQ-016 seg encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any value 10-15 SHALL display dash 0111111.
REQ-017 Blink counter bc SHALL count 0..BLINK_DIV-1 and wrap; phase SHALL toggle at bc==BLINK_DIV-1; phase=1 means visible.
REQ-018 Slot SHALL be blanked when adj==1, phase==0, and idx equals sel.
REQ-019 On adj rising 0->1, or sel change while adj==1, bc SHALL clear to 0 and phase SHALL set to 1 that cycle (restart takes priority over terminal-count toggle).
REQ-020 When adj==0, phase SHALL be ignored; no slot blanked; bc keeps running.
REQ-021 dp SHALL be 0 (lit) when idx==2 and adj==0; 1 in all other cases.
REQ-022 Simultaneous frame boundary and blank condition SHALL still load shadow digits; blanking affects outputs only.

Reset
REQ-023 While reset is high: rc=0, idx=0, bc=0, phase=1, shadow digits=0, an=4'b1111, seg=7'b1111111, dp=1, independent of clk_c.
REQ-024 Reset asserted mid-frame SHALL abort the frame; first clock edge after deassertion SHALL drive an=1110, seg=1000000 (shadow zeros).
REQ-025 Shadow digits SHALL show zeros until the first frame boundary after reset, then live values.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-026 Reset release, inputs 1,2,3,4 (sec_ones..min_tens), adj=0 -> first frame all slots 1000000; from cycle 17: an 1110/1101/1011/0111 each 4 cycles with seg 1111001/0100100/0110000/0011001; dp=0 only with an=1011.
REQ-027 Change sec_ones 1->7 mid-frame (idx=1) -> slot0 keeps 1111001 until next frame boundary, then 1111000.
REQ-028 adj=1, sel=10 -> an never 1011 during phase=0 (16-cycle windows), slot2 visible in phase=1 windows, dp constant 1.
REQ-029 adj=1, change sel 10->00 during phase=0 -> phase=1 next cycle, bc=0; slot0 visible for next 16 cycles, then blanked 16.
REQ-030 Input digit 4'hC on min_tens -> slot3 seg=0111111 after frame boundary.
REQ-031 Assert reset at idx=2, rc=1 -> outputs at reset values immediately (asynchronously); after release, scan restarts at an=1110.

Source files
------------

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - four-digit multiplexed seven-segment driver for a mm:ss stopwatch
//
// Scans four BCD digits onto a common-anode seven-segment display. Digits are
// captured into shadow registers once per frame so a frame never shows a mix of
// old and new values. In adjust mode the selected digit blinks.
//
// Ports:
//   clk_c     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   sec_ones  in   [3:0] live BCD seconds ones (scan slot 0)
//   sec_tens  in   [3:0] live BCD seconds tens (scan slot 1)
//   min_ones  in   [3:0] live BCD minutes ones (scan slot 2)
//   min_tens  in   [3:0] live BCD minutes tens (scan slot 3)
//   adj       in   adjust mode active
//   sel       in   [1:0] digit under adjustment (slot number)
//   an        out  [3:0] active-low anode enables, bit k = slot k
//   seg       out  [6:0] active-low cathodes {g,f,e,d,c,b,a}
//   dp        out  active-low decimal point, lit on slot 2 outside adjust mode
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk_c,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic       adj,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int BC_W = $clog2(BLINK_DIV);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH_DIV - 1);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_DIV - 1);

  logic [RC_W-1:0]       rc_q, rc_d;
  logic [1:0]            idx_q, idx_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic                  phase_q, phase_d;
  logic [3:0][3:0]       dig_q, dig_d;
  logic                  adj_prev_q, adj_prev_d;
  logic [1:0]            sel_prev_q, sel_prev_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic rc_end;
  logic frame_end;
  logic restart;
  logic blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;  // non-BCD shows a dash
    endcase
  endfunction

  always_comb begin
    rc_end    = (rc_q == RC_MAX);
    frame_end = rc_end && (idx_q == 2'd3);

    rc_d  = rc_end ? '0 : rc_q + 1'b1;
    idx_d = rc_end ? idx_q + 2'd1 : idx_q;

    // Capture all four digits together at the end of slot 3 only.
    dig_d = frame_end ? {min_tens, min_ones, sec_tens, sec_ones} : dig_q;

    // Entering adjust mode or moving to another digit restarts the blink so
    // the newly selected digit is immediately visible for a full half-period.
    restart    = adj && (!adj_prev_q || (sel != sel_prev_q));
    adj_prev_d = adj;
    sel_prev_d = sel;

    if (restart) begin
      bc_d    = '0;
      phase_d = 1'b1;
    end else if (bc_q == BC_MAX) begin
      bc_d    = '0;
      phase_d = ~phase_q;
    end else begin
      bc_d    = bc_q + 1'b1;
      phase_d = phase_q;
    end

    blank = adj && !phase_q && (idx_q == sel);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = seg_decode(dig_q[idx_q]);
    dp_d  = !((idx_q == 2'd2) && !adj);
  end

  always_ff @(posedge clk_c or posedge reset) begin
    if (reset) begin
      rc_q       <= '0;
      idx_q      <= 2'd0;
      bc_q       <= '0;
      phase_q    <= 1'b1;
      dig_q      <= '0;
      adj_prev_q <= 1'b0;
      sel_prev_q <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
    end else begin
      rc_q       <= rc_d;
      idx_q      <= idx_d;
      bc_q       <= bc_d;
      phase_q    <= phase_d;
      dig_q      <= dig_d;
      adj_prev_q <= adj_prev_d;
      sel_prev_q <= sel_prev_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - self-checking bench for stopwatch_display
module tb_stopwatch_display;

  logic       clk_c = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sec_ones = 4'd1;
  logic [3:0] sec_tens = 4'd2;
  logic [3:0] min_ones = 4'd3;
  logic [3:0] min_tens = 4'd4;
  logic       adj = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  stopwatch_display #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk_c(clk_c), .reset(reset),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .adj(adj), .sel(sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk_c = ~clk_c;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time is counted in clock edges since reset release. The scan slot,
  // frame boundary and blink phase are pure functions of that count and of the
  // edge at which the blink was last restarted.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
  end

  int         m_n = 0;
  int         m_o = 0;
  int         m_shadow [4];
  logic       m_prev_adj = 1'b0;
  logic [1:0] m_prev_sel = 2'd0;
  logic       m_phase = 1'b1;
  logic [3:0] exp_an = 4'b1111;
  logic [6:0] exp_seg = 7'b1111111;
  logic       exp_dp = 1'b1;

  always @(posedge clk_c or posedge reset) begin
    if (reset) begin
      m_n = 0; m_o = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 0;
      m_prev_adj = 1'b0; m_prev_sel = 2'd0; m_phase = 1'b1;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
    end else begin
      int slot;
      logic ph;
      slot = (m_n / 4) % 4;
      ph = (((m_n - m_o) / 16) % 2) == 0;
      if (adj && !ph && slot == int'(sel)) exp_an = 4'b1111;
      else exp_an = ~(4'b0001 << slot);
      exp_seg = seg_tab[m_shadow[slot]];
      exp_dp = (slot == 2 && !adj) ? 1'b0 : 1'b1;
      if (m_n % 16 == 15) begin
        m_shadow[0] = int'(sec_ones); m_shadow[1] = int'(sec_tens);
        m_shadow[2] = int'(min_ones); m_shadow[3] = int'(min_tens);
      end
      if (adj && (!m_prev_adj || sel != m_prev_sel)) m_o = m_n + 1;
      m_prev_adj = adj;
      m_prev_sel = sel;
      m_n++;
      m_phase = (((m_n - m_o) / 16) % 2) == 0;
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk_c) begin
    if (cmp_en) begin
      check("model_an", {8'd0, an}, {8'd0, exp_an});
      check("model_seg", {5'd0, seg}, {5'd0, exp_seg});
      check("model_dp", {11'd0, dp}, {11'd0, exp_dp});
    end
  end

  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk_c);
    #1;
  endtask

  initial begin
    int seen;
    bit found;

    #12;
    check("reset_an", {8'd0, an}, 12'h00f);
    check("reset_seg", {5'd0, seg}, 12'h07f);
    check("reset_dp", {11'd0, dp}, 12'h001);
    cmp_en = 1'b1;
    @(negedge clk_c);
    reset = 1'b0;

    // First frame shows shadow zeros; live digits appear from edge 17.
    wait_edges(1);
    check("first_edge_an", {8'd0, an}, 12'h00e);
    check("first_edge_seg", {5'd0, seg}, 12'h040);
    wait_edges(16);
    check("edge17_an", {8'd0, an}, 12'h00e);
    check("edge17_seg", {5'd0, seg}, 12'h079);
    wait_edges(8);
    check("edge25_an", {8'd0, an}, 12'h00b);
    check("edge25_seg", {5'd0, seg}, 12'h030);
    check("edge25_dp", {11'd0, dp}, 12'h000);

    // Change sec_ones while slot 1 is scanned; takes effect next frame.
    wait_edges(12);
    sec_ones = 4'd7;
    wait_edges(12);
    check("edge49_an", {8'd0, an}, 12'h00e);
    check("edge49_seg", {5'd0, seg}, 12'h078);

    // Non-BCD digit shows a dash on slot 3 after the next frame boundary.
    min_tens = 4'hC;
    wait_edges(28);
    check("dash_an", {8'd0, an}, 12'h007);
    check("dash_seg", {5'd0, seg}, 12'h03f);

    // Adjust minutes ones: slot 2 blinks, decimal point stays off.
    adj = 1'b1;
    sel = 2'd2;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      wait_edges(1);
      check("adj_dp", {11'd0, dp}, 12'h001);
      if (an == 4'b1011) seen++;
    end
    check("adj_slot2_visible", {11'd0, seen > 0}, 12'h001);

    // Move selection during the dark half: slot 0 visible for a full half-period.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!m_phase) begin found = 1'b1; break; end
      wait_edges(1);
    end
    check("reach_phase0", {11'd0, found}, 12'h001);
    sel = 2'd0;
    wait_edges(1);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      wait_edges(1);
      if (an == 4'b1111) seen++;
    end
    check("sel0_no_blank", seen[11:0], 12'h000);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      wait_edges(1);
      if (an == 4'b1111) seen++;
    end
    check("sel0_blank_after", seen[11:0], 12'h004);

    // Asynchronous reset at slot 2, refresh count 1.
    adj = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_n % 16 == 9) begin found = 1'b1; break; end
      wait_edges(1);
    end
    check("reach_idx2_rc1", {11'd0, found}, 12'h001);
    #2 reset = 1'b1;
    #1;
    check("async_reset_an", {8'd0, an}, 12'h00f);
    check("async_reset_seg", {5'd0, seg}, 12'h07f);
    check("async_reset_dp", {11'd0, dp}, 12'h001);
    wait_edges(2);
    check("held_reset_an", {8'd0, an}, 12'h00f);
    @(negedge clk_c);
    reset = 1'b0;
    wait_edges(1);
    check("restart_an", {8'd0, an}, 12'h00e);
    check("restart_seg", {5'd0, seg}, 12'h040);
    check("restart_dp", {11'd0, dp}, 12'h001);
    wait_edges(20);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
